emisor: RTL

EMISOR -- requirements
Module: emisor

---
 rtl/emisor_pkg.sv | 30 +++
 rtl/emisor_encoder8b10b.sv | 106 ++++++++++
 rtl/emisor.sv | 86 ++++++++
 3 files changed

// File: rtl/emisor_pkg.sv
// Shared constants for the emisor 8b/10b serial transmitter.
// Symbol codes are held in wire order: bit 0 is bit 'a', the first bit on the line.
package emisor_pkg;

    localparam int SYM_W = 10;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] BIT_CNT_LAST = 4'd9;

    // K28.5 comma: 0011111010 (RD-) and 1100000101 (RD+) read a..j.
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0101111100;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1010000011;

    // Width select carried with each word; the reserved code behaves as 8-bit.
    typedef enum logic [1:0] {
        DS_8B   = 2'b00,
        DS_16B  = 2'b01,
        DS_32B  = 2'b10,
        DS_RSVD = 2'b11
    } data_sel_e;

    // Number of bytes a word contributes to the buffer.
    function automatic logic [2:0] bytes_for_sel(input logic [1:0] sel);
        case (data_sel_e'(sel))
            DS_16B:  return 3'd2;
            DS_32B:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/emisor_encoder8b10b.sv
// Combinational 8b/10b encoder. Data bytes go through the 5b/6b and 3b/4b
// tables with running disparity; k=1 emits the K28.5 comma (the only control
// symbol this transmitter uses) and ignores data8.
module encoder8b10b
    import emisor_pkg::*;
(
    input  logic [7:0]       data8,
    input  logic             k,
    input  logic             rdIn,
    output logic [SYM_W-1:0] data10,
    output logic             rdOut
);

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [5:0] w_6b_neg;   // abcdei for RD-, 'a' in the MSB (table reading order)
    logic [5:0] w_6b;
    logic [3:0] w_4b_neg;   // fghj for RD-, 'f' in the MSB
    logic [3:0] w_4b;
    logic       w_6b_unbal;
    logic       w_4b_unbal;
    logic       w_rd_mid;
    logic       w_alt7;

    assign w_x = data8[4:0];
    assign w_y = data8[7:5];

    // 5b/6b code as seen from negative running disparity
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_6b_neg = 6'b000000;
        case (w_x)
            5'd0:  w_6b_neg = 6'b100111;
            5'd1:  w_6b_neg = 6'b011101;
            5'd2:  w_6b_neg = 6'b101101;
            5'd3:  w_6b_neg = 6'b110001;
            5'd4:  w_6b_neg = 6'b110101;
            5'd5:  w_6b_neg = 6'b101001;
            5'd6:  w_6b_neg = 6'b011001;
            5'd7:  w_6b_neg = 6'b111000;
            5'd8:  w_6b_neg = 6'b111001;
            5'd9:  w_6b_neg = 6'b100101;
            5'd10: w_6b_neg = 6'b010101;
            5'd11: w_6b_neg = 6'b110100;
            5'd12: w_6b_neg = 6'b001101;
            5'd13: w_6b_neg = 6'b101100;
            5'd14: w_6b_neg = 6'b011100;
            5'd15: w_6b_neg = 6'b010111;
            5'd16: w_6b_neg = 6'b011011;
            5'd17: w_6b_neg = 6'b100011;
            5'd18: w_6b_neg = 6'b010011;
            5'd19: w_6b_neg = 6'b110010;
            5'd20: w_6b_neg = 6'b001011;
            5'd21: w_6b_neg = 6'b101010;
            5'd22: w_6b_neg = 6'b011010;
            5'd23: w_6b_neg = 6'b111010;
            5'd24: w_6b_neg = 6'b110011;
            5'd25: w_6b_neg = 6'b100110;
            5'd26: w_6b_neg = 6'b010110;
            5'd27: w_6b_neg = 6'b110110;
            5'd28: w_6b_neg = 6'b001110;
            5'd29: w_6b_neg = 6'b101110;
            5'd30: w_6b_neg = 6'b011110;
            default: w_6b_neg = 6'b101011;
        endcase
    end

    // Unbalanced codes and D.07 are inverted at RD+; an unbalanced code flips RD.
    assign w_6b_unbal = ($countones(w_6b_neg) != 3);
    assign w_6b       = (rdIn && (w_6b_unbal || w_x == 5'd7)) ? ~w_6b_neg : w_6b_neg;
    assign w_rd_mid   = rdIn ^ w_6b_unbal;

    // D.x.A7 replaces D.x.P7 where P7 would create a run of five equal bits.
    assign w_alt7 = w_rd_mid ? (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)
                             : (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20);

    // 3b/4b code as seen from negative disparity after the 6b sub-block
    always_comb begin
        w_4b_neg = 4'b0000;
        case (w_y)
            3'd0:    w_4b_neg = 4'b1011;
            3'd1:    w_4b_neg = 4'b1001;
            3'd2:    w_4b_neg = 4'b0101;
            3'd3:    w_4b_neg = 4'b1100;
            3'd4:    w_4b_neg = 4'b1101;
            3'd5:    w_4b_neg = 4'b1010;
            3'd6:    w_4b_neg = 4'b0110;
            default: w_4b_neg = w_alt7 ? 4'b0111 : 4'b1110;
        endcase
    end

    assign w_4b_unbal = ($countones(w_4b_neg) != 2);
    assign w_4b       = (w_rd_mid && (w_4b_unbal || w_y == 3'd3)) ? ~w_4b_neg : w_4b_neg;

    // Reorder sub-blocks into wire order (a at bit 0) or select the comma for fill
    always_comb begin
        data10 = rdIn ? K28_5_RDP : K28_5_RDN;
        rdOut  = ~rdIn;
        if (!k) begin
            for (int i = 0; i < 6; i++) data10[i]     = w_6b[5-i];
            for (int i = 0; i < 4; i++) data10[6 + i] = w_4b[3-i];
            rdOut = w_rd_mid ^ w_4b_unbal;
        end
    end

endmodule

// File: rtl/emisor.sv
// emisor: buffers a 1/2/4-byte word, serialises it as 8b/10b symbols one bit
// per clkTx edge, and fills idle symbol slots with K28.5.
module emisor
    import emisor_pkg::*;
(
    input  logic        clkTx,
    input  logic        rst,
    input  logic        enb,
    input  logic [31:0] dataIn,
    input  logic [1:0]  dataS,
    input  logic        validIn,
    output logic        readyOut,
    output logic        serialOut,
    output logic        idleOut
);

    logic [SYM_W-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_rd;       // 1 = positive running disparity
    logic             r_idle;
    logic [31:0]      r_buf;      // head byte in [7:0]
    logic [2:0]       r_count;

    logic             w_fill;
    logic             w_boundary;
    logic             w_accept;
    logic [SYM_W-1:0] w_enc_sym;
    logic             w_enc_rd;

    assign w_fill     = (r_count == 3'd0);
    assign w_boundary = enb && (r_bit_cnt == BIT_CNT_LAST);
    assign w_accept   = enb && validIn && w_fill;

    assign readyOut  = w_fill;
    assign serialOut = r_shift[0];
    assign idleOut   = r_idle;

    encoder8b10b u_encoder (
        .data8  (r_buf[7:0]),
        .k      (w_fill),
        .rdIn   (r_rd),
        .data10 (w_enc_sym),
        .rdOut  (w_enc_rd)
    );

    // Bit position within the current symbol, wrapping 0..9
    always_ff @(posedge clkTx or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_bit_cnt <= '0;
        end else if (enb) begin
            r_bit_cnt <= (r_bit_cnt == BIT_CNT_LAST) ? '0 : r_bit_cnt + 4'd1;
        end
    end

    // Symbol load at the boundary, otherwise shift the current symbol out LSB first
    always_ff @(posedge clkTx or negedge rst) begin
        if (!rst) begin
            r_shift <= K28_5_RDN;
            r_rd    <= 1'b1;
            r_idle  <= 1'b1;
        end else if (w_boundary) begin
            r_shift <= w_enc_sym;
            r_rd    <= w_enc_rd;
            r_idle  <= w_fill;
        end else if (enb) begin
            r_shift <= {1'b0, r_shift[SYM_W-1:1]};
        end
    end

    // Byte buffer: filled on accept, drained one byte per data-symbol load
    always_ff @(posedge clkTx or negedge rst) begin
        // NOTE: the buffer is cleared as well as the count so no stale byte survives a reset.
        if (!rst) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_buf   <= dataIn;
            r_count <= bytes_for_sel(dataS);
        end else if (w_boundary && !w_fill) begin
            r_buf   <= {8'h00, r_buf[31:8]};
            r_count <= r_count - 3'd1;
        end
    end

endmodule
